// File: rtl/aes_pkg.sv
// Shared constants and controller state encoding for the AES stream-mode controller.
package aes_pkg;

  localparam int unsigned KEYLEN_W = 4;

  localparam logic [KEYLEN_W-1:0] AES_128_BIT_KEY = 4'h0;
  localparam logic [KEYLEN_W-1:0] AES_256_BIT_KEY = 4'h2;

  localparam logic AES_ENCIPHER = 1'b1;
  localparam logic AES_DECIPHER = 1'b0;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_KEY_INIT  = 4'd1,
    ST_KEY_GUARD = 4'd2,
    ST_KEY_WAIT  = 4'd3,
    ST_ACCEPT    = 4'd4,
    ST_BLK_NEXT  = 4'd5,
    ST_BLK_GUARD = 4'd6,
    ST_BLK_WAIT  = 4'd7,
    ST_OUTPUT    = 4'd8
  } cbc_state_t;

endpackage

// File: rtl/aes_cbc_chain.sv
// CBC chaining register plus the pre-core and post-core XOR muxing.
module aes_cbc_chain #(
  parameter int unsigned BLK_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load_iv,
  input  logic [BLK_W-1:0] i_iv,
  input  logic             i_update,
  input  logic             i_mode,
  input  logic             i_encdec,
  input  logic [BLK_W-1:0] i_in_blk,
  input  logic [BLK_W-1:0] i_core_result,
  output logic [BLK_W-1:0] o_core_block_c,
  output logic [BLK_W-1:0] o_out_data_c
);
  import aes_pkg::*;

  logic [BLK_W-1:0] r_chain;
  logic             w_cbc_enc;
  logic             w_cbc_dec;

  assign w_cbc_enc = (i_mode == MODE_CBC) && (i_encdec == AES_ENCIPHER);
  assign w_cbc_dec = (i_mode == MODE_CBC) && (i_encdec == AES_DECIPHER);

  // Encrypt chains on ciphertext (core output); decrypt chains on ciphertext (core input).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
    end else if (i_load_iv) begin
      r_chain <= i_iv;
    end else if (i_update) begin
      if (w_cbc_enc) begin
        r_chain <= i_core_result;
      end else if (w_cbc_dec) begin
        r_chain <= i_in_blk;
      end
    end
  end

  assign o_core_block_c = w_cbc_enc ? (i_in_blk ^ r_chain) : i_in_blk;
  assign o_out_data_c   = w_cbc_dec ? (i_core_result ^ r_chain) : i_core_result;

endmodule

// File: rtl/aes_cbc_ctrl.sv
// Stream-side ECB/CBC mode controller driving the aes_main init/next/ready handshake.
module aes_cbc_ctrl #(
  parameter int unsigned KEY_W = 256,
  parameter int unsigned BLK_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic [3:0]       keylen_in,
  input  logic [BLK_W-1:0] iv_in,
  input  logic             mode_in,
  input  logic             encdec_in,
  output logic             busy,
  output logic             msg_done,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [BLK_W-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_W-1:0] m_data,
  output logic             m_last,
  output logic             core_init,
  output logic             core_next,
  output logic             core_encdec,
  output logic [KEY_W-1:0] core_key,
  output logic [3:0]       core_keylen,
  output logic [BLK_W-1:0] core_block,
  input  logic             core_ready,
  input  logic [BLK_W-1:0] core_result
);
  import aes_pkg::*;

  cbc_state_t       r_state;
  cbc_state_t       w_state_nxt;

  logic             r_busy;
  logic             r_s_ready;
  logic             r_m_valid;
  logic             r_m_last;
  logic             r_msg_done;
  logic             r_core_init;
  logic             r_core_next;
  logic             w_busy_nxt;
  logic             w_s_ready_nxt;
  logic             w_m_valid_nxt;
  logic             w_m_last_nxt;
  logic             w_msg_done_nxt;
  logic             w_core_init_nxt;
  logic             w_core_next_nxt;

  logic [KEY_W-1:0] r_key;
  logic [3:0]       r_keylen;
  logic             r_mode;
  logic             r_encdec;
  logic [BLK_W-1:0] r_in;
  logic             r_last;
  logic [BLK_W-1:0] r_m_data;

  logic             w_start_acc;
  logic             w_blk_acc;
  logic             w_result_cap;
  logic [BLK_W-1:0] w_out_data;

  assign w_start_acc  = (r_state == ST_IDLE) && start;
  assign w_blk_acc    = (r_state == ST_ACCEPT) && s_valid;
  assign w_result_cap = (r_state == ST_BLK_WAIT) && core_ready;

  // State and state-decoded outputs, registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_msg_done  <= 1'b0;
      r_core_init <= 1'b0;
      r_core_next <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_m_last    <= w_m_last_nxt;
      r_msg_done  <= w_msg_done_nxt;
      r_core_init <= w_core_init_nxt;
      r_core_next <= w_core_next_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_msg_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE:      if (start) w_state_nxt = ST_KEY_INIT;
      ST_KEY_INIT:  w_state_nxt = ST_KEY_GUARD;
      ST_KEY_GUARD: w_state_nxt = ST_KEY_WAIT;
      ST_KEY_WAIT:  if (core_ready) w_state_nxt = ST_ACCEPT;
      ST_ACCEPT:    if (s_valid) w_state_nxt = ST_BLK_NEXT;
      ST_BLK_NEXT:  w_state_nxt = ST_BLK_GUARD;
      ST_BLK_GUARD: w_state_nxt = ST_BLK_WAIT;
      ST_BLK_WAIT:  if (core_ready) w_state_nxt = ST_OUTPUT;
      ST_OUTPUT: begin
        if (m_ready) begin
          if (r_last) begin
            w_state_nxt    = ST_IDLE;
            w_msg_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_ACCEPT;
          end
        end
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_s_ready_nxt   = (w_state_nxt == ST_ACCEPT);
    w_m_valid_nxt   = (w_state_nxt == ST_OUTPUT);
    w_m_last_nxt    = (w_state_nxt == ST_OUTPUT) && r_last;
    w_core_init_nxt = (w_state_nxt == ST_KEY_INIT);
    w_core_next_nxt = (w_state_nxt == ST_BLK_NEXT);
  end

  // Message config, input block and output block holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key    <= '0;
      r_keylen <= '0;
      r_mode   <= 1'b0;
      r_encdec <= 1'b0;
      r_in     <= '0;
      r_last   <= 1'b0;
      r_m_data <= '0;
    end else begin
      if (w_start_acc) begin
        r_key    <= key_in;
        r_keylen <= keylen_in;
        r_mode   <= mode_in;
        r_encdec <= encdec_in;
      end
      if (w_blk_acc) begin
        r_in   <= s_data;
        r_last <= s_last;
      end
      if (w_result_cap) begin
        r_m_data <= w_out_data;
      end
    end
  end

  aes_cbc_chain #(
    .BLK_W (BLK_W)
  ) u_chain (
    .clk            (clk),
    .reset          (reset),
    .i_load_iv      (w_start_acc),
    .i_iv           (iv_in),
    .i_update       (w_result_cap),
    .i_mode         (r_mode),
    .i_encdec       (r_encdec),
    .i_in_blk       (r_in),
    .i_core_result  (core_result),
    .o_core_block_c (core_block),
    .o_out_data_c   (w_out_data)
  );

  assign busy        = r_busy;
  assign msg_done    = r_msg_done;
  assign s_ready     = r_s_ready;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_last      = r_m_last;
  assign core_init   = r_core_init;
  assign core_next   = r_core_next;
  assign core_encdec = r_encdec;
  assign core_key    = r_key;
  assign core_keylen = r_keylen;

endmodule

// File: doc/aes_cbc_ctrl.md
# aes_cbc_ctrl

Stream-side mode controller that drives the `aes_main` core's `init`/`next`/`ready` interface. It turns a valid/ready block stream into ECB or CBC encryption or decryption. It sits between a DMA/bus front-end and `aes_main`: it loads the key once per message, then issues one `next` per block, applies CBC chaining and returns results on an output stream with backpressure.

## Interface
- `KEY_W`, default 256: key bus width; matches `aes_main` key port.
- `BLK_W`, default 128: block width; fixed by AES.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches `key_in`, `keylen_in`, `iv_in`, `mode_in`, `encdec_in`; accepted only in IDLE.
- `key_in` in KEY_W, `keylen_in` in 4 (0 = 128-bit, 2 = 256-bit), `iv_in` in 128, `mode_in` in 1 (0 = ECB, 1 = CBC), `encdec_in` in 1 (1 = encipher).
- `busy`  out  1  high whenever the FSM is not IDLE.
- `msg_done`  out  1  one-cycle pulse after the `m_last` handshake.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 128, `s_last` in 1: input block stream.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 128, `m_last` out 1: output block stream.
- `core_init` out 1, `core_next` out 1, `core_encdec` out 1, `core_key` out KEY_W, `core_keylen` out 4, `core_block` out 128: drive `aes_main`.
- `core_ready` in 1, `core_result` in 128: from `aes_main`.

## Operation
- **States:** IDLE, KEY_INIT, KEY_GUARD, KEY_WAIT, ACCEPT, BLK_NEXT, BLK_GUARD, BLK_WAIT, OUTPUT.
- **IDLE:** on `start`, latch the config registers, load `chain_reg` from `iv_in`, go to KEY_INIT.
- **KEY_INIT:** `core_init`=1 for exactly one cycle, then KEY_GUARD.
- **KEY_GUARD:** one cycle in which `core_ready` is ignored, because the core deasserts it one cycle after sampling `init`. Then KEY_WAIT.
- **KEY_WAIT:** wait for `core_ready`=1, then ACCEPT.
- **ACCEPT:** `s_ready`=1. On `s_valid`, capture `s_data` into `in_reg` and `s_last` into `last_reg`, then BLK_NEXT.
- **BLK_NEXT:** `core_next`=1 for one cycle, then BLK_GUARD, then BLK_WAIT.
- **BLK_WAIT:** when `core_ready`=1, register the output into `m_data`, then OUTPUT.
- **OUTPUT:** `m_valid`=1. On `m_ready`:
  - if `last_reg`: pulse `msg_done` and go to IDLE;
  - otherwise go to ACCEPT.
- **`core_block` (combinational from registers):**
  - ECB, or CBC decrypt: `in_reg`.
  - CBC encrypt: `in_reg ^ chain_reg`.
- **Output data:**
  - CBC decrypt: `m_data` = `core_result ^ chain_reg`.
  - Otherwise: `m_data` = `core_result`.
- **Chain update,** at the cycle `m_data` is registered:
  - CBC encrypt: `chain_reg` <= `core_result`.
  - CBC decrypt: `chain_reg` <= `in_reg`.
  - ECB: `chain_reg` unchanged.
- **Config stability:** `core_key`, `core_keylen` and `core_encdec` come from the latched registers and are stable for the whole message.
- **`start` outside IDLE:** ignored, with no effect on state or registers.
- **Reset values:** all outputs 0, all registers 0, FSM to IDLE. This applies even mid-block; the core is then re-initialised by the next `start`.

## Timing
- Input acceptance is at most one block in flight, no pipelining. `s_ready` is high only in ACCEPT and never while OUTPUT is pending.
- Start to first `s_ready` = 3 + T_init cycles, where T_init is the core key-expansion time (cycles `core_ready` stays low).
- Block latency: accept at cycle t → `core_next` at t+1 → `m_valid` at t+3+T_blk. T_blk is the number of cycles `core_ready` stays low after `next`.
- Under backpressure, `m_data` and `m_last` are held stable while `m_valid`=1 && `m_ready`=0.
- `m_last` = `last_reg`, valid only while `m_valid`=1.
- `msg_done` asserts in the cycle after the final handshake, the same cycle `busy` falls.

## Structure
- Shared package `aes_pkg`:
  - AES_128_BIT_KEY=4'h0, AES_256_BIT_KEY=4'h2
  - AES_ENCIPHER=1'b1, AES_DECIPHER=1'b0
  - MODE_ECB=1'b0, MODE_CBC=1'b1
  - the state encoding of this controller.
- One natural sub-module: `aes_cbc_chain`, which holds `chain_reg` and the pre/post XOR muxing keyed on mode/encdec. The FSM stays in `aes_cbc_ctrl`.
- `aes_main` is instantiated by the parent, not inside this block.

## Test plan
- **ECB encrypt:** key 2b7e151628aed2a6abf7158809cf4f3c (128-bit), block 6bc1bee22e409f96e93d7e117393172a, `s_last`=1 → `m_data`=3ad77bb40d7a3660a89ecaf32466ef97, `m_last`=1, then `msg_done` pulse.
- **CBC encrypt two blocks:** same key, IV 000102030405060708090a0b0c0d0e0f.
  - Inputs: 6bc1bee2…172a, then ae2d8a571e03ac9c9eb76fac45af8e51.
  - Outputs: 7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2.
- **CBC decrypt:** the two ciphertexts above with the same key and IV → 6bc1bee2…172a, then ae2d8a57…8e51. Also repeat with 256-bit key 603deb10…dff4, ECB: f3eed1bdb5d2a03c064b5a7e3db181f8 → 6bc1bee2…172a.
- **Backpressure:** hold `m_ready`=0 for 5 cycles → `m_valid` stays 1, `m_data` is unchanged, `s_ready` stays 0. Data is correct after release.
- **Start while busy:** pulse `start` with a different key during BLK_WAIT → ignored, and the result matches the original key.
- **Reset mid-block:** assert `reset` in BLK_WAIT → the next cycle has all outputs 0 and FSM IDLE. A following full message produces the correct NIST result.
